// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported fixed-latency memory.
// Data wins ties until fetch has lost MAX_WAIT times in a row.
module mem_arbiter #(
   parameter int LATENCY  = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_valid,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [3:0] MAX_W  = 4'(MAX_WAIT);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   // Request attributes frozen at grant; port=1 means data port.
   typedef struct packed {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic [1:0]  state;
   logic [3:0]  starve;
   logic [3:0]  wcnt;
   req_t        lat;
   logic [31:0] if_rdata_q;
   logic [31:0] dm_rdata_q;
   logic        grant_fetch;

   // Fetch wins when alone, or when it has been starved MAX_WAIT times.
   assign grant_fetch = if_req & (~dm_req | (starve == MAX_W));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         starve     <= '0;
         wcnt       <= '0;
         lat        <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (if_req | dm_req) begin
                  state <= S_ISSUE;
                  if (grant_fetch) begin
                     lat    <= '{port: 1'b0, we: 1'b0, addr: if_addr, wdata: 32'h0};
                     starve <= '0;
                  end else begin
                     lat <= '{port: 1'b1, we: dm_we, addr: dm_addr, wdata: dm_wdata};
                     if (if_req) starve <= starve + 4'd1;
                  end
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
               wcnt  <= LAT_M1;
            end
            S_WAIT: begin
               if (wcnt == 4'd0) begin
                  state <= S_DONE;
                  if (lat.port) dm_rdata_q <= lat.we ? 32'h0 : mem_rdata;
                  else          if_rdata_q <= mem_rdata;
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign mem_en    = (state == S_ISSUE);
   assign mem_we    = mem_en & lat.we;
   assign mem_addr  = lat.addr;
   assign mem_wdata = lat.wdata;
   assign if_valid  = (state == S_DONE) & ~lat.port;
   assign dm_valid  = (state == S_DONE) &  lat.port;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LATENCY=2 instance for the main scenarios,
// LATENCY=1 instance for the short-latency timing.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   logic        if_req_a = 0, dm_req_a = 0, dm_we_a = 0;
   logic [31:0] if_addr_a = 0, dm_addr_a = 0, dm_wdata_a = 0;
   logic [31:0] if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
   logic        if_valid_a, dm_valid_a, mem_en_a, mem_we_a, busy_a;

   logic        if_req_b = 0, dm_req_b = 0, dm_we_b = 0;
   logic [31:0] if_addr_b = 0, dm_addr_b = 0, dm_wdata_b = 0;
   logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
   logic        if_valid_b, dm_valid_b, mem_en_b, mem_we_b, busy_b;

   mem_arbiter #(.LATENCY(2), .MAX_WAIT(4)) u_a (
      .clk(clk), .rst(rst),
      .if_req(if_req_a), .if_addr(if_addr_a), .if_rdata(if_rdata_a), .if_valid(if_valid_a),
      .dm_req(dm_req_a), .dm_we(dm_we_a), .dm_addr(dm_addr_a), .dm_wdata(dm_wdata_a),
      .dm_rdata(dm_rdata_a), .dm_valid(dm_valid_a),
      .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
      .mem_rdata(mem_rdata_a), .busy(busy_a));

   mem_arbiter #(.LATENCY(1), .MAX_WAIT(2)) u_b (
      .clk(clk), .rst(rst),
      .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_valid(if_valid_b),
      .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
      .dm_rdata(dm_rdata_b), .dm_valid(dm_valid_b),
      .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b), .busy(busy_b));

   // Memory contents: one fixed word, everything else addr ^ A5A50000.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a == 32'h0040_0000) ? 32'h8C08_0000 : (a ^ 32'hA5A5_0000);
   endfunction

   // Read data appears only in the cycle LATENCY after mem_en; garbage otherwise.
   logic [15:0]       en_pa = '0, en_pb = '0;
   logic [15:0][31:0] ad_pa = '0, ad_pb = '0;
   always @(posedge clk) begin
      en_pa <= {en_pa[14:0], mem_en_a};
      ad_pa <= {ad_pa[14:0], mem_addr_a};
      en_pb <= {en_pb[14:0], mem_en_b};
      ad_pb <= {ad_pb[14:0], mem_addr_b};
   end
   assign mem_rdata_a = en_pa[1] ? mem_val(ad_pa[1]) : 32'hBAD0_BAD0;
   assign mem_rdata_b = en_pb[0] ? mem_val(ad_pb[0]) : 32'hBAD0_BAD0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      nchk++;
      if ({busy_a, mem_en_a, mem_we_a, if_valid_a, dm_valid_a} !== 5'b0) begin
         nerr++;
         $display("FAIL reset_ctrl: busy/en/we/ifv/dmv=%b want 00000",
                  {busy_a, mem_en_a, mem_we_a, if_valid_a, dm_valid_a});
      end
      nchk++;
      if ({if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a} !== 128'h0) begin
         nerr++;
         $display("FAIL reset_data: ifr=%h dmr=%h addr=%h wd=%h want all 0",
                  if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a);
      end
      rst = 1'b0;
   endtask

   task automatic test_fetch();
      if_addr_a = 32'h0040_0000;
      if_req_a  = 1'b1;
      tick(); // t+1: ISSUE
      nchk++;
      if (mem_en_a !== 1'b1 || mem_we_a !== 1'b0 || mem_addr_a !== 32'h0040_0000 || busy_a !== 1'b1) begin
         nerr++;
         $display("FAIL fetch_issue: en=%b we=%b addr=%h busy=%b want 1 0 00400000 1",
                  mem_en_a, mem_we_a, mem_addr_a, busy_a);
      end
      tick(); // t+2
      nchk++;
      if (mem_en_a !== 1'b0 || busy_a !== 1'b1 || mem_addr_a !== 32'h0040_0000) begin
         nerr++;
         $display("FAIL fetch_wait: en=%b busy=%b addr=%h want 0 1 00400000", mem_en_a, busy_a, mem_addr_a);
      end
      tick(); // t+3
      nchk++;
      if (if_valid_a !== 1'b0) begin
         nerr++;
         $display("FAIL fetch_early: if_valid=%b want 0", if_valid_a);
      end
      tick(); // t+4: DONE
      nchk++;
      if (if_valid_a !== 1'b1 || dm_valid_a !== 1'b0 || if_rdata_a !== 32'h8C08_0000) begin
         nerr++;
         $display("FAIL fetch_done: ifv=%b dmv=%b rdata=%h want 1 0 8c080000", if_valid_a, dm_valid_a, if_rdata_a);
      end
      if_req_a = 1'b0;
      tick(); // t+5
      nchk++;
      if (if_valid_a !== 1'b0 || busy_a !== 1'b0 || if_rdata_a !== 32'h8C08_0000) begin
         nerr++;
         $display("FAIL fetch_after: ifv=%b busy=%b rdata=%h want 0 0 8c080000", if_valid_a, busy_a, if_rdata_a);
      end
   endtask

   task automatic test_write();
      dm_addr_a  = 32'h1000_8000;
      dm_wdata_a = 32'hDEAD_BEEF;
      dm_we_a    = 1'b1;
      dm_req_a   = 1'b1;
      tick(); // ISSUE
      nchk++;
      if (mem_en_a !== 1'b1 || mem_we_a !== 1'b1 || mem_addr_a !== 32'h1000_8000 || mem_wdata_a !== 32'hDEAD_BEEF) begin
         nerr++;
         $display("FAIL write_issue: en=%b we=%b addr=%h wd=%h want 1 1 10008000 deadbeef",
                  mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a);
      end
      tick();
      nchk++;
      if (mem_en_a !== 1'b0 || mem_we_a !== 1'b0 || mem_wdata_a !== 32'hDEAD_BEEF) begin
         nerr++;
         $display("FAIL write_wait: en=%b we=%b wd=%h want 0 0 deadbeef", mem_en_a, mem_we_a, mem_wdata_a);
      end
      tick();
      tick(); // DONE
      nchk++;
      if (dm_valid_a !== 1'b1 || if_valid_a !== 1'b0 || dm_rdata_a !== 32'h0 || if_rdata_a !== 32'h8C08_0000) begin
         nerr++;
         $display("FAIL write_done: dmv=%b ifv=%b dmr=%h ifr=%h want 1 0 0 8c080000",
                  dm_valid_a, if_valid_a, dm_rdata_a, if_rdata_a);
      end
      dm_req_a = 1'b0;
      dm_we_a  = 1'b0;
      tick();
   endtask

   task automatic test_contention();
      logic exp_dm;
      if_addr_a = 32'h0040_0100;
      dm_addr_a = 32'h1000_0040;
      dm_we_a   = 1'b0;
      if_req_a  = 1'b1;
      dm_req_a  = 1'b1;
      for (int g = 0; g < 10; g++) begin
         exp_dm = (g % 5) != 4;
         tick(); // ISSUE
         nchk++;
         if (mem_en_a !== 1'b1 || mem_addr_a !== (exp_dm ? 32'h1000_0040 : 32'h0040_0100)) begin
            nerr++;
            $display("FAIL contend_grant g=%0d: en=%b addr=%h want 1 %h", g, mem_en_a, mem_addr_a,
                     exp_dm ? 32'h1000_0040 : 32'h0040_0100);
         end
         tick();
         tick();
         tick(); // DONE
         nchk++;
         if ({if_valid_a, dm_valid_a} !== {~exp_dm, exp_dm} ||
             (exp_dm ? dm_rdata_a !== 32'hB5A5_0040 : if_rdata_a !== 32'hA5E5_0100)) begin
            nerr++;
            $display("FAIL contend_done g=%0d: ifv=%b dmv=%b ifr=%h dmr=%h want data_port=%b", g,
                     if_valid_a, dm_valid_a, if_rdata_a, dm_rdata_a, exp_dm);
         end
         if (g == 9) begin
            if_req_a = 1'b0;
            dm_req_a = 1'b0;
         end
         tick(); // IDLE
      end
   endtask

   task automatic test_hold_inputs();
      dm_addr_a = 32'h1000_8000;
      dm_we_a   = 1'b0;
      dm_req_a  = 1'b1;
      tick(); // ISSUE
      nchk++;
      if (mem_addr_a !== 32'h1000_8000) begin
         nerr++;
         $display("FAIL hold_issue: addr=%h want 10008000", mem_addr_a);
      end
      tick(); // WAIT: inputs move, and a short-lived fetch request comes and goes
      dm_addr_a = 32'h1000_8004;
      if_req_a  = 1'b1;
      tick();
      if_req_a  = 1'b0;
      nchk++;
      if (mem_addr_a !== 32'h1000_8000) begin
         nerr++;
         $display("FAIL hold_addr: addr=%h want 10008000", mem_addr_a);
      end
      tick(); // DONE
      nchk++;
      if (dm_valid_a !== 1'b1 || if_valid_a !== 1'b0 || dm_rdata_a !== 32'hB5A5_8000) begin
         nerr++;
         $display("FAIL hold_done: dmv=%b ifv=%b dmr=%h want 1 0 b5a58000", dm_valid_a, if_valid_a, dm_rdata_a);
      end
      dm_req_a = 1'b0;
      tick();
      tick();
      nchk++;
      if (dm_valid_a !== 1'b0 || if_valid_a !== 1'b0 || busy_a !== 1'b0 || mem_en_a !== 1'b0) begin
         nerr++;
         $display("FAIL hold_after: dmv=%b ifv=%b busy=%b en=%b want 0 0 0 0",
                  dm_valid_a, if_valid_a, busy_a, mem_en_a);
      end
   endtask

   task automatic test_reset_mid_wait();
      if_addr_a = 32'h0040_0000;
      if_req_a  = 1'b1;
      tick(); // ISSUE
      tick(); // WAIT
      rst = 1'b1;
      tick();
      rst = 1'b0;
      nchk++;
      if (busy_a !== 1'b0 || if_valid_a !== 1'b0 || if_rdata_a !== 32'h0) begin
         nerr++;
         $display("FAIL rstwait_abort: busy=%b ifv=%b ifr=%h want 0 0 0", busy_a, if_valid_a, if_rdata_a);
      end
      tick();
      nchk++;
      if (mem_en_a !== 1'b1 || mem_addr_a !== 32'h0040_0000) begin
         nerr++;
         $display("FAIL rstwait_regrant: en=%b addr=%h want 1 00400000", mem_en_a, mem_addr_a);
      end
      tick();
      tick();
      nchk++;
      if (if_valid_a !== 1'b0) begin
         nerr++;
         $display("FAIL rstwait_early: ifv=%b want 0", if_valid_a);
      end
      tick();
      nchk++;
      if (if_valid_a !== 1'b1 || if_rdata_a !== 32'h8C08_0000) begin
         nerr++;
         $display("FAIL rstwait_done: ifv=%b ifr=%h want 1 8c080000", if_valid_a, if_rdata_a);
      end
      if_req_a = 1'b0;
      tick();
   endtask

   task automatic test_latency1();
      if_addr_b = 32'h0040_0000;
      if_req_b  = 1'b1;
      tick(); // ISSUE
      nchk++;
      if (mem_en_b !== 1'b1 || {mem_we_b, mem_wdata_b} !== 33'h0 || mem_addr_b !== 32'h0040_0000) begin
         nerr++;
         $display("FAIL lat1_issue: en=%b we=%b wd=%h addr=%h want 1 0 0 00400000",
                  mem_en_b, mem_we_b, mem_wdata_b, mem_addr_b);
      end
      tick();
      nchk++;
      if (if_valid_b !== 1'b0) begin
         nerr++;
         $display("FAIL lat1_early: ifv=%b want 0", if_valid_b);
      end
      tick(); // t+3
      nchk++;
      if (if_valid_b !== 1'b1 || if_rdata_b !== 32'h8C08_0000) begin
         nerr++;
         $display("FAIL lat1_done: ifv=%b ifr=%h want 1 8c080000", if_valid_b, if_rdata_b);
      end
      if_req_b = 1'b0;
      tick();
      dm_addr_b = 32'h1000_0040;
      dm_we_b   = 1'b0;
      dm_req_b  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(); // ISSUE every 4 cycles
         nchk++;
         if (mem_en_b !== 1'b1) begin
            nerr++;
            $display("FAIL lat1_b2b_issue k=%0d: en=%b want 1", k, mem_en_b);
         end
         tick();
         tick(); // DONE
         nchk++;
         if (dm_valid_b !== 1'b1 || if_valid_b !== 1'b0 || dm_rdata_b !== 32'hB5A5_0040) begin
            nerr++;
            $display("FAIL lat1_b2b_done k=%0d: dmv=%b ifv=%b dmr=%h want 1 0 b5a50040",
                     k, dm_valid_b, if_valid_b, dm_rdata_b);
         end
         if (k == 2) dm_req_b = 1'b0;
         tick(); // IDLE
         nchk++;
         if (mem_en_b !== 1'b0 || busy_b !== 1'b0) begin
            nerr++;
            $display("FAIL lat1_b2b_idle k=%0d: en=%b busy=%b want 0 0", k, mem_en_b, busy_b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_write();
      test_contention();
      test_hold_inputs();
      test_reset_mid_wait();
      test_latency1();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
